// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle ADD/SUB/MUL controller sharing one adder, valid/ready in and out.
//
// Ports:
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready      request handshake; op (00 ADD, 01 SUB, 10 MUL, 11 reserved), a, b unsigned
//   out_valid/out_ready    result handshake; result, flag (carry/borrow/overflow), err (unsupported op)
//
// Build option: define ALU_SEQ_MUL_EN to compile in the shift-add multiplier;
// without it op 10 is answered like the reserved op.

module full_adder #(
    parameter int W = 16
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);
    assign {cout, s} = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, cin};
endmodule

module alu_sequencer #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  flag,
    output logic                  err
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] DONE = 2'd3;
`ifdef ALU_SEQ_MUL_EN
    localparam logic [1:0] MUL  = 2'd2;
    localparam int         CW   = $clog2(DATA_WIDTH);
`endif

    logic [1:0]            state;
    logic                  sub;
    logic [DATA_WIDTH-1:0] a_r, b_r, x, y, s;
    logic                  cin, cout;
`ifdef ALU_SEQ_MUL_EN
    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] hi, lo;
`endif

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;

    // Adder operand steering: EXEC uses a +/- b, MUL accumulates a into hi when lo[0] is set.
    always_comb begin
        x   = a_r;
        y   = sub ? ~b_r : b_r;
        cin = sub;
`ifdef ALU_SEQ_MUL_EN
        if (state == MUL) begin
            x   = hi;
            y   = lo[0] ? a_r : '0;
            cin = 1'b0;
        end
`endif
    end

    full_adder #(.W(DATA_WIDTH)) u_add (
        .x    (x),
        .y    (y),
        .cin  (cin),
        .s    (s),
        .cout (cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sub    <= 1'b0;
            a_r    <= '0;
            b_r    <= '0;
            result <= '0;
            flag   <= 1'b0;
            err    <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    sub <= op[0];
                    a_r <= a;
                    b_r <= b;
                    if (!op[1]) begin
                        state <= EXEC;
`ifdef ALU_SEQ_MUL_EN
                    end else if (!op[0]) begin
                        state <= MUL;
                        cnt   <= '0;
                        hi    <= '0;
                        lo    <= b;
`endif
                    end else begin
                        state  <= DONE;
                        result <= '0;
                        flag   <= 1'b0;
                        err    <= 1'b1;
                    end
                end
                EXEC: begin
                    state  <= DONE;
                    result <= s;
                    flag   <= sub ? ~cout : cout;
                    err    <= 1'b0;
                end
`ifdef ALU_SEQ_MUL_EN
                // {hi,lo} <= {cout,s,lo} >> 1; the last pass also latches the product.
                MUL: begin
                    hi  <= {cout, s[DATA_WIDTH-1:1]};
                    lo  <= {s[0], lo[DATA_WIDTH-1:1]};
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(DATA_WIDTH - 1)) begin
                        state  <= DONE;
                        result <= {s[0], lo[DATA_WIDTH-1:1]};
                        flag   <= |{cout, s[DATA_WIDTH-1:1]};
                        err    <= 1'b0;
                    end
                end
`endif
                default: if (out_ready) state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: scoreboard bench for alu_sequencer (handshakes, latency, backpressure, reset).
module tb_alu_sequencer;
    localparam int W = 16;
`ifdef ALU_SEQ_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [1:0]   op = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready, out_valid, flag, err;
    logic [W-1:0] result;

    typedef struct {
        logic [W-1:0] r;
        logic         f;
        logic         e;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    alu_sequencer #(.DATA_WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag      (flag),
        .err       (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t             t;
        logic [W:0]       sm;
        logic [2*W-1:0]   p;
        t.e = 1'b0;
        if (o == 2'b00) begin
            sm = {1'b0, x} + {1'b0, y};
            t.r = sm[W-1:0]; t.f = sm[W]; t.lat = 1;
        end else if (o == 2'b01) begin
            t.r = x - y; t.f = x < y; t.lat = 1;
        end else if (o == 2'b10 && MUL_EN) begin
            p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
            t.r = p[W-1:0]; t.f = |p[2*W-1:W]; t.lat = W;
        end else begin
            t.r = '0; t.f = 1'b0; t.e = 1'b1; t.lat = 0;
        end
        return t;
    endfunction

    // Drive one request, then wait (bounded) for out_valid and score it; returns with result presented.
    task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t t;
        int   cyc;
        sb.push_back(model(o, x, y));
        check("in_ready_before", in_ready, 1);
        in_valid = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        in_valid = 1'b0; op = 2'($urandom); a = W'($urandom); b = W'($urandom);
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            check("busy_in_ready", in_ready, 0);
            @(posedge clk); #1;
            cyc++;
        end
        t = sb.pop_front();
        check("latency", cyc, t.lat);
        check("result", result, t.r);
        check("flag", flag, t.f);
        check("err", err, t.e);
        check("done_in_ready", in_ready, 0);
    endtask

    task automatic retire();
        @(posedge clk); #1;
        check("idle_in_ready", in_ready, 1);
        check("idle_out_valid", out_valid, 0);
    endtask

    initial begin
        #2;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_flag", flag, 0);
        check("rst_err", err, 0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        issue(2'b00, 16'hFFFF, 16'h0001); retire();
        issue(2'b01, 16'h0003, 16'h0005); retire();
        issue(2'b01, 16'h0005, 16'h0003); retire();
        issue(2'b10, 16'h00FF, 16'h0101); retire();
        issue(2'b10, 16'h0100, 16'h0100); retire();
        issue(2'b11, 16'h1234, 16'h5678); retire();

        out_ready = 1'b0;
        issue(2'b00, 16'h1234, 16'h1111);
        repeat (5) begin
            in_valid = 1'b1; op = 2'b01; a = W'($urandom); b = W'($urandom);
            @(posedge clk); #1;
            check("bp_result", result, 16'h2345);
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        retire();

        in_valid = 1'b1; op = MUL_EN ? 2'b10 : 2'b00; a = 16'h0123; b = 16'h0456;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (MUL_EN) repeat (7) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_result", result, 0);
        check("mid_rst_flag", flag, 0);
        check("mid_rst_err", err, 0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        issue(2'b00, 16'h0002, 16'h0003); retire();

        repeat (6) begin
            issue(2'($urandom_range(0, 3)), W'($urandom), W'($urandom));
            retire();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
